// File: rtl/ajuste_pkg.sv
// Shared encodings for the set-up front-end: field codes, group bases,
// mode switch encodings and repeat-FSM states.
package ajuste_pkg;

  // Field codes understood by the downstream counters
  localparam logic [3:0] CAMPO_NINGUNO = 4'd0;
  localparam logic [3:0] CAMPO_SS      = 4'd1;
  localparam logic [3:0] CAMPO_MM      = 4'd2;
  localparam logic [3:0] CAMPO_HH      = 4'd3;
  localparam logic [3:0] CAMPO_DD      = 4'd4;
  localparam logic [3:0] CAMPO_MES     = 4'd5;
  localparam logic [3:0] CAMPO_AA      = 4'd6;
  localparam logic [3:0] CAMPO_SS_T    = 4'd8;
  localparam logic [3:0] CAMPO_MM_T    = 4'd9;
  localparam logic [3:0] CAMPO_HH_T    = 4'd10;

  // First field of each group; cursor 0..2 is added on top
  localparam logic [3:0] BASE_RELOJ = CAMPO_SS;
  localparam logic [3:0] BASE_FECHA = CAMPO_DD;
  localparam logic [3:0] BASE_TEMP  = CAMPO_SS_T;

  // sw_modo encodings
  localparam logic [1:0] MODO_RUN   = 2'b00;
  localparam logic [1:0] MODO_RELOJ = 2'b01;
  localparam logic [1:0] MODO_FECHA = 2'b10;
  localparam logic [1:0] MODO_TEMP  = 2'b11;

  // Auto-repeat FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_st_e;

  // Field code for a given mode and cursor position
  function automatic logic [3:0] campo_de(input logic [1:0] modo,
                                          input logic [1:0] cursor);
    logic [3:0] c;
    c = {2'b00, cursor};
    case (modo)
      MODO_RELOJ: campo_de = BASE_RELOJ + c;
      MODO_FECHA: campo_de = BASE_FECHA + c;
      MODO_TEMP:  campo_de = BASE_TEMP + c;
      default:    campo_de = CAMPO_NINGUNO;
    endcase
  endfunction

endpackage

// File: rtl/antirrebote.sv
// One push-button conditioner: 2-flop synchronizer, stable-sample debounce
// counter and a rising-edge pulse on the debounced level.
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_nivel,
  output logic o_subida
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1, r_s2;
  logic [1:0]    r_vld_pipe;
  logic          r_armado;
  logic          r_nivel, r_nivel_d;
  logic [CW-1:0] r_cnt;

  // Two-flop synchronizer plus a marker of when r_s2 holds real samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_vld_pipe <= '0;
    end else begin
      r_s1       <= i_btn;
      r_s2       <= r_s1;
      r_vld_pipe <= {r_vld_pipe[0], 1'b1};
    end
  end

  // A button held through reset must be seen released once before it can
  // produce a press edge again
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           r_armado <= 1'b0;
    else if (r_vld_pipe[1] && !r_s2)     r_armado <= 1'b1;
  end

  // Debounce: level follows the synced input only after a full run of mismatches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nivel <= 1'b0;
      r_cnt   <= '0;
    end else if (r_s2 != r_nivel) begin
      if (r_cnt == CNT_MAX) begin
        r_nivel <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // Previous debounced level for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_nivel_d <= 1'b0;
    else       r_nivel_d <= r_nivel;
  end

  assign o_nivel  = r_nivel;
  assign o_subida = r_nivel & ~r_nivel_d & r_armado;

endmodule

// File: rtl/control_ajuste_campos.sv
// Set-up front-end: conditions the four buttons and the mode switch, keeps the
// field cursor, and emits single-cycle Arriba/Abajo pulses with auto-repeat.
module control_ajuste_campos
  import ajuste_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [1:0] sw_modo,
  output logic [3:0] contadoresH,
  output logic       Arriba,
  output logic       Abajo,
  output logic       programando
);
  localparam int B_UP = 0, B_DN = 1, B_IZQ = 2, B_DER = 3;
  localparam int TW_D = (REPEAT_DELAY  > 1) ? $clog2(REPEAT_DELAY)  : 1;
  localparam int TW_P = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
  localparam int TW   = (TW_D > TW_P) ? TW_D : TW_P;
  localparam logic [TW-1:0] TMR_DELAY  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] TMR_PERIOD = TW'(REPEAT_PERIOD - 1);

  logic [3:0]    w_btn, w_nivel, w_subida;
  logic [1:0]    r_m1, r_m2, r_modo_prev;
  logic [1:0]    r_cursor, w_cursor_next;
  logic [3:0]    r_campo, w_campo_next;
  logic          r_prog;
  logic          w_modo_cambio, w_campo_cambio;
  rep_st_e       r_st, w_st_next;
  logic [TW-1:0] r_tmr, w_tmr_next;
  logic          r_dir, w_dir_next;        // 1 = up, 0 = down
  logic          r_arr, r_aba, w_arr_next, w_aba_next;
  logic          w_lvl_pr, w_lvl_otro, w_abort;

  assign w_btn = {btn_right, btn_left, btn_down, btn_up};

  for (genvar g = 0; g < 4; g++) begin : g_ar
    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar (
      .clk      (clk),
      .reset    (reset),
      .i_btn    (w_btn[g]),
      .o_nivel  (w_nivel[g]),
      .o_subida (w_subida[g])
    );
  end

  // Mode switch synchronizer and previous synced value for change detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m1        <= MODO_RUN;
      r_m2        <= MODO_RUN;
      r_modo_prev <= MODO_RUN;
    end else begin
      r_m1        <= sw_modo;
      r_m2        <= r_m1;
      r_modo_prev <= r_m2;
    end
  end

  assign w_modo_cambio = (r_m2 != r_modo_prev);

  // Cursor movement: mode change wins, left+right together cancel
  always_comb begin
    w_cursor_next = r_cursor;
    if (w_modo_cambio) begin
      w_cursor_next = 2'd0;
    end else if (r_m2 != MODO_RUN) begin
      if (w_subida[B_DER] && !w_subida[B_IZQ])
        w_cursor_next = (r_cursor == 2'd2) ? 2'd0 : r_cursor + 2'd1;
      else if (w_subida[B_IZQ] && !w_subida[B_DER])
        w_cursor_next = (r_cursor == 2'd0) ? 2'd2 : r_cursor - 2'd1;
    end
  end

  assign w_campo_next   = campo_de(r_m2, w_cursor_next);
  assign w_campo_cambio = (w_campo_next != r_campo);

  // Cursor, field code and programming flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cursor <= 2'd0;
      r_campo  <= CAMPO_NINGUNO;
      r_prog   <= 1'b0;
    end else begin
      r_cursor <= w_cursor_next;
      r_campo  <= w_campo_next;
      r_prog   <= (r_m2 != MODO_RUN);
    end
  end

  assign w_lvl_pr   = r_dir ? w_nivel[B_UP] : w_nivel[B_DN];
  assign w_lvl_otro = r_dir ? w_nivel[B_DN] : w_nivel[B_UP];
  assign w_abort    = !w_lvl_pr || w_lvl_otro || w_campo_cambio || w_modo_cambio;

  // Repeat FSM next state, timer and pulse decisions
  always_comb begin
    w_st_next  = r_st;
    w_tmr_next = r_tmr;
    w_dir_next = r_dir;
    w_arr_next = 1'b0;
    w_aba_next = 1'b0;
    case (r_st)
      ST_IDLE: begin
        if (r_campo != CAMPO_NINGUNO && !w_campo_cambio && !w_modo_cambio &&
            (w_subida[B_UP] ^ w_subida[B_DN])) begin
          w_dir_next = w_subida[B_UP];
          w_arr_next = w_subida[B_UP];
          w_aba_next = w_subida[B_DN];
          w_tmr_next = TMR_DELAY;
          w_st_next  = ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (w_abort) begin
          w_st_next = ST_IDLE;
        end else if (r_tmr == '0) begin
          w_arr_next = r_dir;
          w_aba_next = !r_dir;
          w_tmr_next = TMR_PERIOD;
          w_st_next  = ST_REPEAT;
        end else begin
          w_tmr_next = r_tmr - 1'b1;
        end
      end
      default: w_st_next = ST_IDLE;
    endcase
  end

  // Repeat FSM state and registered pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st  <= ST_IDLE;
      r_tmr <= '0;
      r_dir <= 1'b0;
      r_arr <= 1'b0;
      r_aba <= 1'b0;
    end else begin
      r_st  <= w_st_next;
      r_tmr <= w_tmr_next;
      r_dir <= w_dir_next;
      r_arr <= w_arr_next;
      r_aba <= w_aba_next;
    end
  end

  assign contadoresH = r_campo;
  assign Arriba      = r_arr;
  assign Abajo       = r_aba;
  assign programando = r_prog;

endmodule

// File: tb/tb_control_ajuste_campos.sv
// Bench for control_ajuste_campos: expected pulses go into a scoreboard queue
// as stimulus is issued; a monitor pops and checks each pulse the DUT emits.
module tb_control_ajuste_campos;
  localparam int UP = 0, DN = 1, IZQ = 2, DER = 3;

  logic       clk = 1'b0;
  logic       reset, btn_up, btn_down, btn_left, btn_right;
  logic [1:0] sw_modo;
  logic [3:0] contadoresH;
  logic       Arriba, Abajo, programando;

  typedef struct {
    logic       up;
    logic [3:0] campo;
    int         gap;      // cycles since previous pulse, 0 = not checked
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0, n_pulses = 0;
  int   cyc = 0, last_cyc = 0;

  always #5 clk = ~clk;

  control_ajuste_campos #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .sw_modo     (sw_modo),
    .contadoresH (contadoresH),
    .Arriba      (Arriba),
    .Abajo       (Abajo),
    .programando (programando)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every pulse must match the head of the scoreboard
  initial forever begin
    @(negedge clk);
    if (!reset && (Arriba || Abajo)) begin
      exp_t e;
      int   gap;
      gap = cyc - last_cyc;
      last_cyc = cyc;
      n_pulses++;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: Arriba=%0b Abajo=%0b campo=%0d at cycle %0d",
                 Arriba, Abajo, contadoresH, cyc);
      end else begin
        e = sb.pop_front();
        if ({Arriba, Abajo} != {e.up, !e.up} || contadoresH != e.campo ||
            (e.gap != 0 && gap != e.gap)) begin
          n_err++;
          $display("FAIL pulse: got Arriba=%0b Abajo=%0b campo=%0d gap=%0d, required up=%0b campo=%0d gap=%0d",
                   Arriba, Abajo, contadoresH, gap, e.up, e.campo, e.gap);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int sel, input logic v);
    case (sel)
      UP:      btn_up    = v;
      DN:      btn_down  = v;
      IZQ:     btn_left  = v;
      default: btn_right = v;
    endcase
  endtask

  task automatic hold(input int sel, input int n);
    set_btn(sel, 1'b1);
    tick(n);
    set_btn(sel, 1'b0);
  endtask

  task automatic push(input logic up, input logic [3:0] campo, input int gap);
    exp_t e;
    e.up = up; e.campo = campo; e.gap = gap;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1; sw_modo = 2'b00;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    tick(2);
    chk("rst_campo", contadoresH, 0);
    chk("rst_arriba", Arriba, 0);
    chk("rst_abajo", Abajo, 0);
    chk("rst_prog", programando, 0);

    // 1: timer mode, cursor navigation with wrap
    sw_modo = 2'b11;
    tick(1);
    reset = 1'b0;
    tick(4);
    chk("t1_campo_base", contadoresH, 8);
    chk("t1_prog", programando, 1);
    hold(DER, 10); tick(10); chk("t1_right1", contadoresH, 9);
    hold(DER, 10); tick(10); chk("t1_right2", contadoresH, 10);
    hold(DER, 10); tick(10); chk("t1_right_wrap", contadoresH, 8);
    hold(IZQ, 10); tick(10); chk("t1_left_wrap", contadoresH, 10);

    // 2: short up press on field 9 gives exactly one pulse
    hold(IZQ, 10); tick(10); chk("t2_campo", contadoresH, 9);
    push(1'b1, 4'd9, 0);
    hold(UP, 6); tick(40);
    chk("t2_pending", sb.size(), 0);
    chk("t2_pulses", n_pulses, 1);

    // 3: clock mode, down held 60 cycles: initial + delay + 4 repeats
    sw_modo = 2'b01; tick(5);
    chk("t3_campo", contadoresH, 1);
    push(1'b0, 4'd1, 0);
    push(1'b0, 4'd1, 20);
    for (int i = 0; i < 4; i++) push(1'b0, 4'd1, 8);
    hold(DN, 60); tick(40);
    chk("t3_pending", sb.size(), 0);
    chk("t3_pulses", n_pulses, 7);

    // 4: glitch shorter than debounce, and simultaneous up+down
    hold(UP, 3); tick(15);
    btn_up = 1'b1; btn_down = 1'b1; tick(10);
    btn_up = 1'b0; btn_down = 1'b0; tick(15);
    chk("t4_pulses", n_pulses, 7);

    // 5: mode change during HOLD aborts without a pulse
    sw_modo = 2'b10; tick(5);
    chk("t5_campo_fecha", contadoresH, 4);
    push(1'b1, 4'd4, 0);
    btn_up = 1'b1; tick(12);
    sw_modo = 2'b01; tick(30);
    chk("t5_campo_reloj", contadoresH, 1);
    btn_up = 1'b0; tick(15);
    chk("t5_pending", sb.size(), 0);
    chk("t5_pulses", n_pulses, 8);

    // 6: run mode ignores buttons; reset mid-REPEAT
    sw_modo = 2'b00; tick(5);
    chk("t6_campo_run", contadoresH, 0);
    chk("t6_prog_run", programando, 0);
    hold(UP, 10); tick(10);
    hold(DER, 10); tick(10);
    chk("t6_campo_run2", contadoresH, 0);
    chk("t6_pulses_run", n_pulses, 8);
    sw_modo = 2'b11; tick(5);
    chk("t6_campo_temp", contadoresH, 8);
    push(1'b1, 4'd8, 0);
    push(1'b1, 4'd8, 20);
    push(1'b1, 4'd8, 8);
    btn_up = 1'b1; tick(38);
    reset = 1'b1; #1;
    chk("t6_rst_campo", contadoresH, 0);
    chk("t6_rst_arriba", Arriba, 0);
    chk("t6_rst_abajo", Abajo, 0);
    chk("t6_rst_prog", programando, 0);
    tick(3);
    reset = 1'b0; tick(40);
    chk("t6_held_after_rst", n_pulses, 11);
    chk("t6_pending", sb.size(), 0);
    chk("t6_campo_after_rst", contadoresH, 8);
    btn_up = 1'b0; tick(15);
    push(1'b1, 4'd8, 0);
    hold(UP, 6); tick(30);
    chk("t6_repress", n_pulses, 12);
    chk("t6_final_pending", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
